// File: rtl/alu_sched.sv
// alu_sched: schedules two requesters onto one shared alu_control/ALU pair.
// Define ALU_SCHED_FAIR_EN for round-robin tie-breaking; otherwise requester 0 wins IDLE ties.
module alu_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [4:0]  op0,
    input  logic [4:0]  op1,
    input  logic [1:0]  funct0,
    input  logic [1:0]  funct1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic [4:0]  alu_op,
    output logic [1:0]  alu_funct,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;
    state_t r_state, w_next;
    logic   r_win, w_win, w_load, w_pick;
`ifdef ALU_SCHED_FAIR_EN
    logic   r_ptr;
    assign w_pick = (req0 && req1) ? r_ptr : req1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 1'b0;
        else if (w_load)
            r_ptr <= ~w_win;
    end
`else
    assign w_pick = ~req0;
`endif
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_win  = r_win;
        case (r_state)
            IDLE: begin
                w_load = req0 || req1;
                w_win  = w_pick;
                w_next = w_load ? EXEC : IDLE;
            end
            EXEC: w_next = RESP;
            RESP: begin
                // The served requester's req is ignored; only the other one can take over.
                w_load = (alu_op != 5'b00000) && (r_win ? req0 : req1);
                w_win  = ~r_win;
                w_next = (alu_op == 5'b00000) ? HALT : w_load ? EXEC : IDLE;
            end
            HALT: w_next = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_win     <= 1'b0;
            alu_op    <= '0;
            alu_funct <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            result    <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_win     <= w_win;
                alu_op    <= w_win ? op1 : op0;
                alu_funct <= w_win ? funct1 : funct0;
                alu_a     <= w_win ? a1 : a0;
                alu_b     <= w_win ? b1 : b0;
            end
            if (r_state == EXEC)
                result <= alu_out;
        end
    end
    assign gnt0   = (r_state == EXEC) && !r_win;
    assign gnt1   = (r_state == EXEC) &&  r_win;
    assign done0  = (r_state == RESP) && !r_win;
    assign done1  = (r_state == RESP) &&  r_win;
    assign halted = (r_state == HALT);
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a small behavioural ALU on alu_out.
module tb_alu_sched;
    localparam logic [4:0] ADD = 5'b11011, SUB = 5'b00001, HLT = 5'b00000;
    logic clk = 1'b0, rst_n = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [4:0] op0 = '0, op1 = '0;
    logic [1:0] funct0 = '0, funct1 = '0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [4:0] alu_op;
    logic [1:0] alu_funct;
    logic [15:0] alu_a, alu_b, alu_out, result;
    logic gnt0, gnt1, done0, done1, halted;
    int n_chk = 0, n_fail = 0;
    typedef struct {logic w; logic [15:0] r;} exp_t;
    exp_t sb[$];

    alu_sched dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .funct0(funct0), .funct1(funct1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [4:0] o, input logic [1:0] f,
                                          input logic [15:0] a, input logic [15:0] b);
        return (o == ADD) ? a + b : (o == SUB) ? a - b : a ^ b ^ {14'd0, f};
    endfunction
    assign alu_out = alu_f(alu_op, alu_funct, alu_a, alu_b);

    task automatic push(input logic w, input logic [4:0] o, input logic [1:0] f,
                        input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.w = w;
        e.r = alu_f(o, f, a, b);
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Done monitor: pops the scoreboard and checks the exclusivity rules every cycle.
    always @(negedge clk) begin
        exp_t e;
        n_chk++;
        if ((gnt0 && gnt1) || (done0 && done1) || (gnt0 && done0) || (gnt1 && done1)) begin
            n_fail++;
            $display("FAIL exclusive gnt=%b%b done=%b%b", gnt1, gnt0, done1, done0);
        end
        if (done0 || done1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done done=%b%b result=%h", done1, done0, result);
            end else begin
                e = sb.pop_front();
                if ({done1, result} !== {e.w, e.r}) begin
                    n_fail++;
                    $display("FAIL sb_done got who=%b result=%h want who=%b result=%h",
                             done1, result, e.w, e.r);
                end
            end
        end
    end

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_async got %h want 0",
                     {gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b});
        end
        tick;
        tick;
        n_chk++;
        if ({gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_held got %h want 0",
                     {gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        req0 = 1'b1; op0 = ADD; funct0 = 2'b00; a0 = 16'h0003; b0 = 16'h0004;
        push(1'b0, ADD, 2'b00, 16'h0003, 16'h0004);
        tick;
        n_chk++;
        if ({gnt1, gnt0, done1, done0} !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_gnt got gnt=%b%b done=%b%b want gnt=01 done=00", gnt1, gnt0, done1, done0);
        end
        tick;
        n_chk++;
        if ({gnt1, gnt0, done1, done0} !== 4'b0001 || result !== 16'h0007) begin
            n_fail++;
            $display("FAIL single_done got gnt=%b%b done=%b%b result=%h want done=01 result=0007",
                     gnt1, gnt0, done1, done0, result);
        end
        req0 = 1'b0;
        tick;
        n_chk++;
        if ({gnt1, gnt0, done1, done0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle got gnt=%b%b done=%b%b want 0", gnt1, gnt0, done1, done0);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] want;
        logic who;
        req0 = 1'b1; op0 = ADD; funct0 = 2'b00; a0 = 16'd1;  b0 = 16'd2;
        req1 = 1'b1; op1 = SUB; funct1 = 2'b00; a1 = 16'd10; b1 = 16'd3;
        push(1'b0, ADD, 2'b00, 16'd1, 16'd2);
        push(1'b1, SUB, 2'b00, 16'd10, 16'd3);
        push(1'b0, ADD, 2'b00, 16'd5, 16'd6);
        push(1'b1, 5'b00010, 2'b01, 16'd20, 16'd4);
        for (int k = 1; k <= 8; k++) begin
            tick;
            who = ((k - 1) / 2) % 2 == 1;
            want = (k % 2 == 1) ? {who, !who, 2'b00} : {2'b00, who, !who};
            n_chk++;
            if ({gnt1, gnt0, done1, done0} !== want) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d got gnt=%b%b done=%b%b want %b", k, gnt1, gnt0, done1, done0, want);
            end
            if (k == 2) begin a0 = 16'd5; b0 = 16'd6; end
            if (k == 4) begin op1 = 5'b00010; funct1 = 2'b01; a1 = 16'd20; b1 = 16'd4; end
            if (k == 6) req0 = 1'b0;
            if (k == 8) req1 = 1'b0;
        end
        tick;
        n_chk++;
        if ({gnt1, gnt0, done1, done0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_idle got gnt=%b%b done=%b%b want 0", gnt1, gnt0, done1, done0);
        end
    endtask

    task automatic test_tie;
        logic first;
`ifdef ALU_SCHED_FAIR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        req0 = 1'b1; op0 = ADD; a0 = 16'd100; b0 = 16'd1;
        push(1'b0, ADD, 2'b00, 16'd100, 16'd1);
        tick;
        tick;
        req0 = 1'b0;
        tick;
        req0 = 1'b1; op0 = ADD; a0 = 16'd7; b0 = 16'd8;
        req1 = 1'b1; op1 = ADD; a1 = 16'd9; b1 = 16'd9; funct1 = 2'b00;
        push(first, ADD, 2'b00, first ? 16'd9 : 16'd7, first ? 16'd9 : 16'd8);
        push(!first, ADD, 2'b00, first ? 16'd7 : 16'd9, first ? 16'd8 : 16'd9);
        tick;
        n_chk++;
        if ({gnt1, gnt0} !== {first, !first}) begin
            n_fail++;
            $display("FAIL tie_winner got gnt=%b%b want %b%b", gnt1, gnt0, first, !first);
        end
        tick;
        if (first) req1 = 1'b0; else req0 = 1'b0;
        tick;
        n_chk++;
        if ({gnt1, gnt0} !== {!first, first}) begin
            n_fail++;
            $display("FAIL tie_handoff got gnt=%b%b want %b%b", gnt1, gnt0, !first, first);
        end
        tick;
        req0 = 1'b0; req1 = 1'b0;
        tick;
    endtask

    task automatic test_operand_hold;
        req1 = 1'b1; op1 = ADD; funct1 = 2'b00; a1 = 16'h1234; b1 = 16'h0001;
        push(1'b1, ADD, 2'b00, 16'h1234, 16'h0001);
        tick;
        n_chk++;
        if (gnt1 !== 1'b1 || alu_a !== 16'h1234) begin
            n_fail++;
            $display("FAIL hold_gnt got gnt1=%b alu_a=%h want 1 1234", gnt1, alu_a);
        end
        a1 = 16'hFFFF; b1 = 16'hAAAA; op1 = SUB;
        tick;
        n_chk++;
        if (done1 !== 1'b1 || alu_a !== 16'h1234 || alu_op !== ADD || result !== 16'h1235) begin
            n_fail++;
            $display("FAIL hold_done got done1=%b alu_a=%h alu_op=%b result=%h want 1 1234 11011 1235",
                     done1, alu_a, alu_op, result);
        end
        req1 = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        req1 = 1'b1; op1 = ADD; funct1 = 2'b00; a1 = 16'h0010; b1 = 16'h0020;
        tick;
        n_chk++;
        if (gnt1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_gnt got gnt1=%b want 1", gnt1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outs got %h want 0",
                     {gnt0, gnt1, done0, done1, halted, result, alu_op, alu_funct, alu_a, alu_b});
        end
        a1 = 16'h0042; b1 = 16'h0001;
        push(1'b1, ADD, 2'b00, 16'h0042, 16'h0001);
        tick;
        rst_n = 1'b1;
        tick;
        n_chk++;
        if ({gnt1, gnt0, done1, done0} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_regrant got gnt=%b%b done=%b%b want gnt=10", gnt1, gnt0, done1, done0);
        end
        tick;
        req1 = 1'b0;
        tick;
    endtask

    task automatic test_halt;
        req1 = 1'b1; op1 = HLT; funct1 = 2'b00; a1 = 16'h0005; b1 = 16'h0006;
        push(1'b1, HLT, 2'b00, 16'h0005, 16'h0006);
        tick;
        req0 = 1'b1; op0 = ADD; funct0 = 2'b00; a0 = 16'h0100; b0 = 16'h0023;
        tick;
        n_chk++;
        if (done1 !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_done got done1=%b halted=%b want 1 0", done1, halted);
        end
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_chk++;
            if ({halted, gnt1, gnt0, done1, done0} !== 5'b10000) begin
                n_fail++;
                $display("FAIL halt_absorb%0d got halted=%b gnt=%b%b done=%b%b want halted=1 rest 0",
                         k, halted, gnt1, gnt0, done1, done0);
            end
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset got halted=%b want 0", halted);
        end
        push(1'b0, ADD, 2'b00, 16'h0100, 16'h0023);
        tick;
        rst_n = 1'b1;
        tick;
        n_chk++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_regrant got gnt0=%b want 1", gnt0);
        end
        tick;
        req0 = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_tie;
        test_operand_hold;
        test_reset_mid;
        test_halt;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
